reset_conditioner: RTL and testbench
====================================

# reset_conditioner

Reset source conditioner for the MTL display demo. It merges the board power-on reset, the user reset pushbutton and the PLL lock indicator into one clean active-low reset, oRSTN. That reset drives the staged reset-delay generator, which releases the SDRAM, reader and LCD stages. Glitches on the key and the lock line never reach the downstream reset tree, and every reset event is counted for debug on LEDs.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a key level change (20 ms at 50 MHz).
- LOCK_CYCLES, 65536: consecutive synchronized lock-high samples required before release.
- MIN_ASSERT, 16: minimum cycles oRSTN is held low after entering S_HOLD.
- iCLK  in  1  free-running 50 MHz board clock.
- iRSTN  in  1  reset, asynchronous, active-low.
- iKEY_N  in  1  raw pushbutton, active-low, asynchronous, bouncy.
- iPLL_LOCKED  in  1  PLL lock, asynchronous to iCLK.
- oRSTN  out  1  conditioned reset, active-low; feeds the reset-delay generator.
- oSTATE  out  2  FSM state: 0 S_HOLD, 1 S_LOCKWAIT, 2 S_RUN, 3 S_KEYRST.
- oRESET_CNT  out  8  saturating count of resets issued from S_RUN.

## Operation
- **Synchronizers.** iKEY_N and iPLL_LOCKED each pass through a 2-flop synchronizer. Reset values: key 1, lock 0.
- **Debouncer.**
  - Counter clears whenever key_sync == key_stable; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the inputs still differing, key_stable takes key_sync and the counter clears.
  - key_stable therefore changes after exactly DEBOUNCE_CYCLES consecutive differing samples.
  - Reset value of key_stable is 1.
- **FSM.** Reset state is S_HOLD, with the state counter cleared.
  - S_HOLD: counter increments each cycle. At MIN_ASSERT-1 -> S_LOCKWAIT, counter cleared.
  - S_LOCKWAIT: counter increments while lock_sync=1 and clears when lock_sync=0. It saturates at LOCK_CYCLES. -> S_RUN when the count reaches LOCK_CYCLES and key_stable=1. With key_stable=0 the FSM stays, counter saturated.
  - S_RUN:
    - lock_sync=0 -> S_HOLD.
    - Otherwise, key_stable=0 -> S_KEYRST.
    - Lock loss has priority over a simultaneous key press.
    - Each exit from S_RUN increments oRESET_CNT, saturating at 255.
  - S_KEYRST: waits for key_stable=1 (debounced release) -> S_HOLD, counter cleared. Lock loss here is ignored; S_HOLD/S_LOCKWAIT re-qualify the lock.
- **Outputs.**
  - oRSTN is a dedicated flop, set on the edge that enters S_RUN and cleared on the edge that leaves it. It is glitch-free.
  - oSTATE is the state register.
- **Reset values.** oRSTN=0, oSTATE=0, oRESET_CNT=0.
- **Counter widths.**
  - Debounce counter: clog2(DEBOUNCE_CYCLES) bits.
  - State counter: clog2(max(LOCK_CYCLES, MIN_ASSERT)+1) bits.
  - Neither counter wraps.

## Timing
- Edges are counted from 1 after the iRSTN deassertion.
- With the lock already high and the key released:
  - S_LOCKWAIT is entered at edge MIN_ASSERT.
  - oRSTN rises at edge MIN_ASSERT+LOCK_CYCLES. lock_sync is valid from edge 2, so it is never the limiting factor when MIN_ASSERT≥2.
- Key press, with iKEY_N low before edge k and held:
  - key_stable=0 after edge k+1+DEBOUNCE_CYCLES.
  - oRSTN falls after edge k+2+DEBOUNCE_CYCLES.
- Lock loss in S_RUN, with iPLL_LOCKED low before edge k: oRSTN falls after edge k+2.
- Bounces shorter than DEBOUNCE_CYCLES never change key_stable.
- A lock dropout during S_LOCKWAIT restarts the full LOCK_CYCLES qualification.
- iRSTN assertion at any time:
  - Forces all state to reset values immediately, asynchronously.
  - Clears oRESET_CNT.
  - The synchronizers restart, so a stale key_stable is never carried over.
- Minimum low pulse width of oRSTN is MIN_ASSERT+LOCK_CYCLES cycles, which guarantees the downstream delay counter restarts cleanly.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=8, LOCK_CYCLES=16, MIN_ASSERT=4.

1. Power-up with lock high and key released -> oSTATE 0→1 at edge 4, oRSTN=1 and oSTATE=2 at edge 20, oRESET_CNT=0.
2. Key pulses low for 5 cycles, 3 times, in S_RUN -> oRSTN stays 1 and oRESET_CNT stays 0.
3. Key held low from edge k in S_RUN -> oRSTN=0 after edge k+10 with oSTATE=3. Release, then 8+2 cycles later S_HOLD. oRSTN returns 1 MIN_ASSERT+LOCK_CYCLES after S_HOLD entry, and oRESET_CNT=1.
4. Lock drops for 1 cycle in S_RUN -> oRSTN=0 after edge k+2, full re-qualification follows, oRESET_CNT increments. Then lock toggling every 10 cycles in S_LOCKWAIT -> oRSTN stays 0 and oSTATE stays 1.
5. Lock loss and debounced key press in the same cycle -> oSTATE goes to 0, not 3, and the counter increments by exactly 1. Then 300 forced reset events -> oRESET_CNT saturates at 255.
6. iRSTN asserted mid-S_LOCKWAIT and mid-debounce -> all outputs reset to 0 immediately, and power-up timing from scenario 1 repeats exactly.

Source files
------------

// File: rtl/reset_conditioner.sv
// -----------------------------------------------------------------------------
// reset_conditioner
//
// Merges the board power-on reset (iRSTN), the user reset pushbutton (iKEY_N)
// and the PLL lock indicator (iPLL_LOCKED) into one clean active-low reset,
// oRSTN, which feeds the staged reset-delay generator. Key bounces and lock
// glitches are filtered out before they can reach the reset tree. Every reset
// issued while running is counted for LED debug.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a key change
//   LOCK_CYCLES      consecutive lock-high samples needed before release
//   MIN_ASSERT       minimum cycles spent in S_HOLD before lock qualification
//
// Ports:
//   iCLK        in   1  free-running board clock
//   iRSTN       in   1  asynchronous active-low reset
//   iKEY_N      in   1  raw pushbutton, active-low, asynchronous, bouncy
//   iPLL_LOCKED in   1  PLL lock, asynchronous to iCLK
//   oRSTN       out  1  conditioned reset, active-low, glitch-free flop output
//   oSTATE      out  2  FSM state: 0 S_HOLD, 1 S_LOCKWAIT, 2 S_RUN, 3 S_KEYRST
//   oRESET_CNT  out  8  saturating count of resets issued from S_RUN
// -----------------------------------------------------------------------------
module reset_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCK_CYCLES     = 65536,
  parameter int MIN_ASSERT      = 16
) (
  input  logic       iCLK,
  input  logic       iRSTN,
  input  logic       iKEY_N,
  input  logic       iPLL_LOCKED,
  output logic       oRSTN,
  output logic [1:0] oSTATE,
  output logic [7:0] oRESET_CNT
);

  // ---------------------------------------------------------------------------
  // Counter sizing
  // ---------------------------------------------------------------------------
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_MAX = (LOCK_CYCLES > MIN_ASSERT) ? LOCK_CYCLES : MIN_ASSERT;
  localparam int ST_W   = $clog2(ST_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] HOLD_LAST = ST_W'(MIN_ASSERT - 1);
  localparam logic [ST_W-1:0] LOCK_LAST = ST_W'(LOCK_CYCLES - 1);
  localparam logic [ST_W-1:0] LOCK_FULL = ST_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_LOCKWAIT = 2'd1,
    S_RUN      = 2'd2,
    S_KEYRST   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers. Bit 0 carries the key, bit 1 the lock.
  // The key idles released (1) and the lock idles unlocked (0), so a fresh
  // reset never sees a phantom key press or a phantom lock.
  // ---------------------------------------------------------------------------
  localparam logic [1:0] SYNC_RST = 2'b01;

  logic [1:0] async_in;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       key_sync;
  logic       lock_sync;

  assign async_in  = {iPLL_LOCKED, iKEY_N};
  assign key_sync  = sync_reg[0];
  assign lock_sync = sync_reg[1];

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      meta_reg <= SYNC_RST;
      sync_reg <= SYNC_RST;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Key debouncer. The counter measures how long the synchronized key has
  // disagreed with the accepted level; any agreeing sample restarts it, so
  // only an uninterrupted run of DEBOUNCE_CYCLES differing samples flips
  // key_stable.
  // ---------------------------------------------------------------------------
  logic            key_stable_reg;
  logic            key_stable_next;
  logic [DB_W-1:0] db_cnt_reg;
  logic [DB_W-1:0] db_cnt_next;

  always_comb begin
    key_stable_next = key_stable_reg;
    db_cnt_next     = '0;
    if (key_sync != key_stable_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        key_stable_next = key_sync;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      key_stable_reg <= 1'b1;
      db_cnt_reg     <= '0;
    end else begin
      key_stable_reg <= key_stable_next;
      db_cnt_reg     <= db_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;
  logic [ST_W-1:0] st_cnt_reg;
  logic [ST_W-1:0] st_cnt_next;
  logic [7:0]      rst_cnt_reg;
  logic [7:0]      rst_cnt_next;
  logic            rstn_reg;
  logic            rstn_next;
  logic            leave_run;

  always_comb begin
    state_next   = state_reg;
    st_cnt_next  = st_cnt_reg;
    rst_cnt_next = rst_cnt_reg;
    leave_run    = 1'b0;

    case (state_reg)
      S_HOLD: begin
        if (st_cnt_reg == HOLD_LAST) begin
          state_next  = S_LOCKWAIT;
          st_cnt_next = '0;
        end else begin
          st_cnt_next = st_cnt_reg + 1'b1;
        end
      end

      S_LOCKWAIT: begin
        if (!lock_sync) begin
          // Any dropout restarts the full qualification window.
          st_cnt_next = '0;
        end else if (st_cnt_reg >= LOCK_LAST) begin
          // The count reaches LOCK_CYCLES on this edge (or already sits
          // there, saturated, while the key is still held down).
          st_cnt_next = LOCK_FULL;
          if (key_stable_reg) begin
            state_next  = S_RUN;
            st_cnt_next = '0;
          end
        end else begin
          st_cnt_next = st_cnt_reg + 1'b1;
        end
      end

      S_RUN: begin
        // Lock loss is tested first so it wins over a simultaneous key press.
        if (!lock_sync) begin
          state_next  = S_HOLD;
          st_cnt_next = '0;
          leave_run   = 1'b1;
        end else if (!key_stable_reg) begin
          state_next = S_KEYRST;
          leave_run  = 1'b1;
        end
      end

      S_KEYRST: begin
        // Lock is deliberately ignored here; S_HOLD and S_LOCKWAIT
        // re-qualify it after the key is released.
        if (key_stable_reg) begin
          state_next  = S_HOLD;
          st_cnt_next = '0;
        end
      end

      default: begin
        state_next  = S_HOLD;
        st_cnt_next = '0;
      end
    endcase

    if (leave_run && (rst_cnt_reg != 8'hFF)) begin
      rst_cnt_next = rst_cnt_reg + 8'd1;
    end
  end

  // The reset output is its own flop, decoded from the next state, so it
  // changes exactly on the edges entering and leaving S_RUN with no
  // combinational decode glitch on the reset tree.
  assign rstn_next = (state_next == S_RUN);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_reg   <= S_HOLD;
      st_cnt_reg  <= '0;
      rst_cnt_reg <= '0;
      rstn_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      st_cnt_reg  <= st_cnt_next;
      rst_cnt_reg <= rst_cnt_next;
      rstn_reg    <= rstn_next;
    end
  end

  assign oRSTN      = rstn_reg;
  assign oSTATE     = state_reg;
  assign oRESET_CNT = rst_cnt_reg;

endmodule

// File: tb/tb_reset_conditioner.sv
// -----------------------------------------------------------------------------
// tb_reset_conditioner
//
// Self-checking bench for reset_conditioner with DEBOUNCE_CYCLES=8,
// LOCK_CYCLES=16, MIN_ASSERT=4. A table of {inputs, cycles, expected outputs}
// records covers power-up, bounce rejection, key reset, lock loss and lock
// toggling; hand-written sequences cover simultaneous key/lock events,
// counter saturation and asynchronous reset; a randomized phase drives both
// inputs with random segments. Every edge is also compared against a
// behavioural model written from the timing rules.
// -----------------------------------------------------------------------------
module tb_reset_conditioner;

  localparam int D = 8;
  localparam int L = 16;
  localparam int M = 4;

  logic       iCLK = 1'b0;
  logic       iRSTN;
  logic       iKEY_N;
  logic       iPLL_LOCKED;
  logic       oRSTN;
  logic [1:0] oSTATE;
  logic [7:0] oRESET_CNT;

  always #5 iCLK = ~iCLK;

  reset_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCK_CYCLES    (L),
    .MIN_ASSERT     (M)
  ) dut (
    .iCLK       (iCLK),
    .iRSTN      (iRSTN),
    .iKEY_N     (iKEY_N),
    .iPLL_LOCKED(iPLL_LOCKED),
    .oRSTN      (oRSTN),
    .oSTATE     (oSTATE),
    .oRESET_CNT (oRESET_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model. Tracks the observable rules: a two-sample
  // input delay, a run length of disagreeing key samples, the age of the
  // current hold phase, and the run length of lock-high samples.
  // ---------------------------------------------------------------------------
  bit m_key_meta, m_key_sync, m_lock_meta, m_lock_sync, m_stable;
  int m_diff_run, m_state, m_hold_age, m_lock_run, m_cnt;

  function automatic void model_reset();
    m_key_meta  = 1'b1;
    m_key_sync  = 1'b1;
    m_lock_meta = 1'b0;
    m_lock_sync = 1'b0;
    m_stable    = 1'b1;
    m_diff_run  = 0;
    m_state     = 0;
    m_hold_age  = 0;
    m_lock_run  = 0;
    m_cnt       = 0;
  endfunction

  function automatic void model_step(input bit key_n, input bit lock);
    int ns;
    ns = m_state;
    case (m_state)
      0: begin
        m_hold_age++;
        if (m_hold_age == M) begin
          ns = 1;
          m_lock_run = 0;
        end
      end
      1: begin
        if (m_lock_sync) m_lock_run = (m_lock_run < L) ? m_lock_run + 1 : L;
        else             m_lock_run = 0;
        if (m_lock_run == L && m_stable) ns = 1 + 1;
      end
      2: begin
        if (!m_lock_sync) begin
          ns = 0;
          m_hold_age = 0;
          if (m_cnt < 255) m_cnt++;
        end else if (!m_stable) begin
          ns = 3;
          if (m_cnt < 255) m_cnt++;
        end
      end
      default: begin
        if (m_stable) begin
          ns = 0;
          m_hold_age = 0;
        end
      end
    endcase
    if (m_key_sync != m_stable) begin
      m_diff_run++;
      if (m_diff_run == D) begin
        m_stable   = m_key_sync;
        m_diff_run = 0;
      end
    end else begin
      m_diff_run = 0;
    end
    m_key_sync  = m_key_meta;
    m_key_meta  = key_n;
    m_lock_sync = m_lock_meta;
    m_lock_meta = lock;
    m_state     = ns;
  endfunction

  // One clock edge: inputs were applied before the edge and are unchanged
  // until after the comparison, so the model sees exactly what the DUT saw.
  task automatic tick();
    @(posedge iCLK);
    #1;
    edge_no++;
    if (!iRSTN) model_reset();
    else        model_step(iKEY_N, iPLL_LOCKED);
    check($sformatf("model_e%0d", edge_no),
          {oRSTN, oSTATE, oRESET_CNT},
          {(m_state == 2), 2'(m_state), 8'(m_cnt)});
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, input string name);
    int waited;
    waited = 0;
    while (oSTATE != s && waited < bound) begin
      tick();
      waited++;
    end
    check(name, oSTATE, s);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    int         cycles;
    logic       key_n;
    logic       lock;
    logic       exp_rstn;
    logic [1:0] exp_state;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input int c, input logic k, input logic l,
                              input logic r, input logic [1:0] s, input logic [7:0] cnt);
    vec_t v;
    v.name      = n;
    v.cycles    = c;
    v.key_n     = k;
    v.lock      = l;
    v.exp_rstn  = r;
    v.exp_state = s;
    v.exp_cnt   = cnt;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    iKEY_N      = v.key_n;
    iPLL_LOCKED = v.lock;
    repeat (v.cycles) tick();
    check(v.name, {oRSTN, oSTATE, oRESET_CNT}, {v.exp_rstn, v.exp_state, v.exp_cnt});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int key_left;
    int lock_left;

    // Power-up: lock high, key released.
    add("pu_e3",      3, 1, 1, 0, 0, 0);
    add("pu_e4",      1, 1, 1, 0, 1, 0);
    add("pu_e19",    15, 1, 1, 0, 1, 0);
    add("pu_e20",     1, 1, 1, 1, 2, 0);
    // Short key bounces in S_RUN.
    for (int i = 0; i < 3; i++) begin
      add($sformatf("bounce_lo%0d", i), 5, 0, 1, 1, 2, 0);
      add($sformatf("bounce_hi%0d", i), 5, 1, 1, 1, 2, 0);
    end
    // Key held, then released.
    add("key_e8",     9, 0, 1, 1, 2, 0);
    add("key_e9",     1, 0, 1, 1, 2, 0);
    add("key_e10",    1, 0, 1, 0, 3, 1);
    add("key_held",   5, 0, 1, 0, 3, 1);
    add("rel_e8",     9, 1, 1, 0, 3, 1);
    add("rel_e9",     1, 1, 1, 0, 3, 1);
    add("rel_e10",    1, 1, 1, 0, 0, 1);
    add("rel_hold",   3, 1, 1, 0, 0, 1);
    add("rel_lw",     1, 1, 1, 0, 1, 1);
    add("rel_lw15",  15, 1, 1, 0, 1, 1);
    add("rel_run",    1, 1, 1, 1, 2, 1);
    // One-cycle lock dropout in S_RUN and full re-qualification.
    add("drop_e0",    1, 1, 0, 1, 2, 1);
    add("drop_e1",    1, 1, 1, 1, 2, 1);
    add("drop_e2",    1, 1, 1, 0, 0, 2);
    add("rq_hold",    3, 1, 1, 0, 0, 2);
    add("rq_lw",      1, 1, 1, 0, 1, 2);
    add("rq_lw15",   15, 1, 1, 0, 1, 2);
    add("rq_run",     1, 1, 1, 1, 2, 2);
    // Lock toggling every 10 cycles while in S_LOCKWAIT.
    add("drop2_e0",   1, 1, 0, 1, 2, 2);
    add("drop2_e1",   1, 1, 1, 1, 2, 2);
    add("drop2_e2",   1, 1, 1, 0, 0, 3);
    add("tog_lo1",   10, 1, 0, 0, 1, 3);
    add("tog_hi1",   10, 1, 1, 0, 1, 3);
    add("tog_lo2",   10, 1, 0, 0, 1, 3);
    add("tog_hi2",   10, 1, 1, 0, 1, 3);
    add("tog_lo3",   10, 1, 0, 0, 1, 3);
    add("final_e16", 17, 1, 1, 0, 1, 3);
    add("final_run",  1, 1, 1, 1, 2, 3);

    // Reset state.
    iRSTN       = 1'b0;
    iKEY_N      = 1'b1;
    iPLL_LOCKED = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_state", {oRSTN, oSTATE, oRESET_CNT}, 0);
    iRSTN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Lock loss and debounced key press land on the same edge.
    iKEY_N = 1'b0;
    repeat (D) tick();
    iPLL_LOCKED = 1'b0;
    repeat (2) tick();
    check("simul_pre", oSTATE, 2);
    tick();
    check("simul_state", oSTATE, 0);
    check("simul_cnt", oRESET_CNT, 4);
    iKEY_N      = 1'b1;
    iPLL_LOCKED = 1'b1;
    wait_state(2, 200, "simul_recover");

    // Force 300 resets to saturate the event counter.
    for (int i = 0; i < 300; i++) begin
      iPLL_LOCKED = 1'b0;
      tick();
      iPLL_LOCKED = 1'b1;
      repeat (2) tick();
      wait_state(2, 100, "sat_rerun");
    end
    check("sat_cnt", oRESET_CNT, 255);

    // Asynchronous reset in the middle of S_LOCKWAIT and of a key debounce.
    iPLL_LOCKED = 1'b0;
    tick();
    iPLL_LOCKED = 1'b1;
    repeat (6) tick();
    repeat (5) tick();
    iKEY_N = 1'b0;
    repeat (3) tick();
    check("pre_arst_state", oSTATE, 1);
    iRSTN = 1'b0;
    #1;
    check("arst_outputs", {oRSTN, oSTATE, oRESET_CNT}, 0);
    iKEY_N = 1'b1;
    repeat (2) tick();
    iRSTN = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Randomized segments on both inputs, with rare asynchronous resets.
    key_left  = 0;
    lock_left = 0;
    for (int t = 0; t < 3000; t++) begin
      if (key_left <= 0) begin
        iKEY_N   = ($urandom_range(0, 3) != 0);
        key_left = int'($urandom_range(1, 20));
      end
      if (lock_left <= 0) begin
        iPLL_LOCKED = ($urandom_range(0, 4) != 0);
        lock_left   = iPLL_LOCKED ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 799) == 0) begin
        iRSTN = 1'b0;
        #1;
        check("rnd_arst", {oRSTN, oSTATE, oRESET_CNT}, 0);
        tick();
        iRSTN = 1'b1;
      end
      tick();
      key_left--;
      lock_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
